// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: synchronises a free-running ripple counter bus into
// the clk domain and captures it once it has held one value for MATCH_COUNT
// consecutive samples. If that never happens within TIMEOUT settle cycles,
// the current sample is captured anyway and flagged with out_err. The
// captured value is offered on a valid/ready handshake.
// Optional build macro RIPPLE_SAMPLER_DELTA_EN adds out_delta: the modulo
// 2^WIDTH difference between this capture and the previously accepted one.
module ripple_count_sampler #(
   parameter int WIDTH       = 65,
   parameter int SYNC_STAGES = 2,
   parameter int MATCH_COUNT = 2,
   parameter int TIMEOUT     = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             sample_req,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_count,
   output logic             out_err
`ifdef RIPPLE_SAMPLER_DELTA_EN
   ,
   output logic [WIDTH-1:0] out_delta
`endif
);

   localparam int RUN_W  = $clog2(MATCH_COUNT + 1);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MATCH_COUNT);
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [WIDTH-1:0]  r_sync [SYNC_STAGES];
   logic [WIDTH-1:0]  w_sync_q;
   logic [WIDTH-1:0]  r_last_q;
   logic [RUN_W-1:0]  r_run;
   logic [RUN_W-1:0]  w_run_next;
   logic [TCNT_W-1:0] r_tcnt;
   logic [TCNT_W-1:0] w_tcnt_next;
   logic              w_capture;
   logic              w_capture_err;
   logic              w_accept;
   logic              r_busy;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_count;
   logic              r_out_err;

   // Saturating increments: the run and settle-time counters never wrap.
   function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
      return (v == RUN_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [TCNT_W-1:0] sat_inc_tcnt(input logic [TCNT_W-1:0] v);
      return (v == TCNT_MAX) ? v : v + 1'b1;
   endfunction

   assign w_sync_q = r_sync[SYNC_STAGES-1];

   // Per-bit synchroniser chain, free running every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= cnt_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // Stability tracking: a fresh run starts on entry and on any value change.
   always_comb begin
      w_run_next  = ((r_run == '0) || (w_sync_q != r_last_q)) ? RUN_W'(1) : sat_inc_run(r_run);
      w_tcnt_next = sat_inc_tcnt(r_tcnt);
   end

   // Next-state and capture decode; stability takes priority over timeout.
   always_comb begin
      w_state_next  = r_state;
      w_capture     = 1'b0;
      w_capture_err = 1'b0;
      w_accept      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (sample_req) w_state_next = S_SETTLE;
         end
         S_SETTLE: begin
            if (w_run_next == RUN_MAX) begin
               w_capture    = 1'b1;
               w_state_next = S_HOLD;
            end else if (w_tcnt_next == TCNT_MAX) begin
               w_capture     = 1'b1;
               w_capture_err = 1'b1;
               w_state_next  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (r_out_valid && out_ready) begin
               w_accept     = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State, settle counters, registered status flags and the captured value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_last_q    <= '0;
         r_run       <= '0;
         r_tcnt      <= '0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_count <= '0;
         r_out_err   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_busy      <= (w_state_next != S_IDLE);
         r_out_valid <= (w_state_next == S_HOLD);
         if (r_state == S_IDLE && sample_req) begin
            r_run  <= '0;
            r_tcnt <= '0;
         end
         if (r_state == S_SETTLE) begin
            r_last_q <= w_sync_q;
            r_run    <= w_run_next;
            r_tcnt   <= w_tcnt_next;
         end
         if (w_capture) begin
            r_out_count <= w_sync_q;
            r_out_err   <= w_capture_err;
         end
      end
   end

`ifdef RIPPLE_SAMPLER_DELTA_EN
   logic [WIDTH-1:0] r_prev_count;
   logic [WIDTH-1:0] r_out_delta;

   // Delta against the last accepted capture, computed at capture time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_count <= '0;
         r_out_delta  <= '0;
      end else begin
         if (w_capture) r_out_delta  <= w_sync_q - r_prev_count;
         if (w_accept)  r_prev_count <= r_out_count;
      end
   end

   assign out_delta = r_out_delta;
`endif

   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign out_count = r_out_count;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Scoreboard bench for ripple_count_sampler: directed stimulus pushes the
// expected capture; a monitor pops and compares on every accepted handshake.
module tb_ripple_count_sampler;

   localparam int W = 65;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] cnt_in = '0;
   logic         sample_req = 1'b0;
   logic         busy;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_count;
   logic         out_err;
`ifdef RIPPLE_SAMPLER_DELTA_EN
   logic [W-1:0] out_delta;
`endif

   ripple_count_sampler #(
      .WIDTH(W), .SYNC_STAGES(2), .MATCH_COUNT(2), .TIMEOUT(15)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cnt_in(cnt_in),
      .sample_req(sample_req),
      .busy(busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_count(out_count),
      .out_err(out_err)
`ifdef RIPPLE_SAMPLER_DELTA_EN
      ,
      .out_delta(out_delta)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] cnt;
      logic [W-1:0] alt;
      bit           alt_ok;
      logic         err;
      bit           has_delta;
      logic [W-1:0] delta;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic exp_t mk(input logic [W-1:0] c, input logic e);
      exp_t x;
      x.cnt = c; x.alt = c; x.alt_ok = 1'b0; x.err = e;
      x.has_delta = 1'b0; x.delta = '0;
      return x;
   endfunction

   // Monitor: compare every accepted output against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got count %0h, expected no output", out_count);
            end else begin
               e = q.pop_front();
               if (e.alt_ok && out_count === e.alt) chk("out_count", out_count, e.alt);
               else chk("out_count", out_count, e.cnt);
               chk("out_err", {{(W-1){1'b0}}, out_err}, {{(W-1){1'b0}}, e.err});
`ifdef RIPPLE_SAMPLER_DELTA_EN
               if (e.has_delta) chk("out_delta", out_delta, e.delta);
`endif
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for out_valid, counting edges; optionally drop the request after
   // the first edge and toggle cnt_in between 0x5 and 0xA after every edge.
   task automatic wait_valid(input int budget, input bit drop_req, input bit toggle, output int lat);
      lat = 0;
      while (lat < budget) begin
         tick();
         lat++;
         if (drop_req) sample_req = 1'b0;
         if (toggle) cnt_in = (cnt_in == W'(5)) ? W'(10) : W'(5);
         if (out_valid) break;
         chk("busy_settle", {{(W-1){1'b0}}, busy}, W'(1));
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL wait_valid_timeout: got out_valid 0 after %0d cycles, expected 1", lat);
      end
   endtask

   task automatic stable_capture(input logic [W-1:0] v, input bit has_d, input logic [W-1:0] d);
      exp_t e;
      int   lat;
      cnt_in = v;
      repeat (6) tick();
      e = mk(v, 1'b0);
      e.has_delta = has_d;
      e.delta = d;
      q.push_back(e);
      sample_req = 1'b1;
      wait_valid(10, 1'b1, 1'b0, lat);
      chk("stable_latency", W'(lat), W'(3));
      tick();
      chk("valid_after_accept", {{(W-1){1'b0}}, out_valid}, '0);
   endtask

   initial begin
      exp_t e;
      int   lat;
      logic [W-1:0] all1;
      all1 = '1;

      // Reset state
      repeat (3) tick();
      chk("rst_busy", {{(W-1){1'b0}}, busy}, '0);
      chk("rst_valid", {{(W-1){1'b0}}, out_valid}, '0);
      chk("rst_count", out_count, '0);
      chk("rst_err", {{(W-1){1'b0}}, out_err}, '0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // 1: stable capture of 0x1234
      cnt_in = W'(16'h1234);
      repeat (10) tick();
      q.push_back(mk(W'(16'h1234), 1'b0));
      sample_req = 1'b1;
      wait_valid(10, 1'b1, 1'b0, lat);
      chk("t1_latency", W'(lat), W'(3));
      chk("t1_busy_hold", {{(W-1){1'b0}}, busy}, W'(1));
      tick();

      // 2: synchronised value changes 0x0F -> 0x10 during SETTLE
      cnt_in = W'(8'h0F);
      repeat (6) tick();
      q.push_back(mk(W'(8'h10), 1'b0));
      cnt_in = W'(8'h10);
      sample_req = 1'b1;
      wait_valid(10, 1'b1, 1'b0, lat);
      chk("t2_latency", W'(lat), W'(4));
      tick();

      // 3: toggling input never settles -> forced capture
      cnt_in = W'(5);
      repeat (4) begin
         tick();
         cnt_in = (cnt_in == W'(5)) ? W'(10) : W'(5);
      end
      e = mk(W'(5), 1'b1);
      e.alt = W'(10);
      e.alt_ok = 1'b1;
      q.push_back(e);
      sample_req = 1'b1;
      wait_valid(25, 1'b1, 1'b1, lat);
      chk("t3_latency", W'(lat), W'(16));
      chk("t3_err_flag", {{(W-1){1'b0}}, out_err}, W'(1));
      tick();

      // 4: backpressure with the request held high
      out_ready = 1'b0;
      cnt_in = W'(16'h2222);
      repeat (6) tick();
      q.push_back(mk(W'(16'h2222), 1'b0));
      sample_req = 1'b1;
      wait_valid(10, 1'b0, 1'b0, lat);
      chk("t4_latency", W'(lat), W'(3));
      cnt_in = W'(8'h77);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t4_hold_valid", {{(W-1){1'b0}}, out_valid}, W'(1));
         chk("t4_hold_count", out_count, W'(16'h2222));
      end
      q.push_back(mk(W'(8'h77), 1'b0));
      out_ready = 1'b1;
      tick();
      chk("t4_idle_busy", {{(W-1){1'b0}}, busy}, '0);
      chk("t4_idle_valid", {{(W-1){1'b0}}, out_valid}, '0);
      tick();
      chk("t4_restart_busy", {{(W-1){1'b0}}, busy}, W'(1));
      sample_req = 1'b0;
      wait_valid(10, 1'b0, 1'b0, lat);
      chk("t4_restart_latency", W'(lat), W'(2));
      tick();

      // 5: asynchronous reset one cycle into SETTLE
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      chk("t5_busy", {{(W-1){1'b0}}, busy}, '0);
      chk("t5_valid", {{(W-1){1'b0}}, out_valid}, '0);
      chk("t5_count", out_count, '0);
      chk("t5_err", {{(W-1){1'b0}}, out_err}, '0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t5_no_capture", {{(W-1){1'b0}}, busy | out_valid}, '0);
      end

      // 6: delta sequence (delta fields checked only when the feature exists)
      stable_capture(W'(12'h100), 1'b1, W'(12'h100));
      stable_capture(W'(12'h180), 1'b1, W'(12'h080));
      stable_capture(all1, 1'b1, all1 - W'(12'h180));
      stable_capture('0, 1'b1, W'(1));

      repeat (4) tick();
      chk("scoreboard_empty", W'(q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
